// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, framing constants and helpers for the UART trigger command path
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CH,
    GET_VAL,
    GET_SUM,
    RESP
  } cmd_state_e;

  localparam int         NUM_CH   = 4;
  localparam logic [7:0] SOF_BYTE = 8'h53;
  localparam logic [7:0] CH_BASE  = 8'h30;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [7:0] CH_LAST  = CH_BASE + 8'(NUM_CH - 1);

  function automatic logic ch_valid(input logic [7:0] b);
    return (b >= CH_BASE) && (b <= CH_LAST);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/uart_trig_cmd_ctrl_if.sv
// rtl/uart_trig_cmd_ctrl_if.sv - RX byte strobe and TX response handshake between UART engines and the sequencer
interface uart_trig_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
  modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap timer; expire pulses when a frame has been silent too long
module uart_gap_timer #(
  parameter int GAP_CYCLES = 120000
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int         W    = $clog2(GAP_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(GAP_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // A byte arriving on the terminal count wins over the timeout
  assign expire = run && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (!run || clear || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uart_trig_cmd_ctrl.sv
// rtl/uart_trig_cmd_ctrl.sv - parses S/ch/value/xor frames from UART RX, updates trigger thresholds, answers ACK/NAK
module uart_trig_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              nrst,
  uart_trig_cmd_ctrl_if.slave bus,
  output logic [7:0]        trig_ch0,
  output logic [7:0]        trig_ch1,
  output logic [7:0]        trig_ch2,
  output logic [7:0]        trig_ch3,
  output logic [NUM_CH-1:0] trig_upd,
  output logic              trig_en,
  output logic              cmd_busy,
  output logic [7:0]        err_cnt
);

  cmd_state_e        state_q;
  logic [7:0]        sum_q;
  logic [7:0]        val_q;
  logic [1:0]        ch_q;
  logic [7:0]        trig_q [NUM_CH];
  logic [NUM_CH-1:0] trig_upd_q;
  logic              trig_en_q;
  logic              cmd_busy_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        err_q;
  logic [7:0]        err_d;

  logic in_frame;
  logic expire;
  logic nak_now;
  logic drop_now;

  assign in_frame = (state_q == GET_CH) || (state_q == GET_VAL) || (state_q == GET_SUM);

  uart_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk    (clk),
    .nrst   (nrst),
    .run    (in_frame),
    .clear  (bus.rx_valid),
    .expire (expire)
  );

  always_comb begin
    nak_now  = 1'b0;
    drop_now = (state_q == RESP) && bus.rx_valid;
    if (bus.rx_valid) begin
      case (state_q)
        GET_CH:  nak_now = !ch_valid(bus.rx_data);
        GET_SUM: nak_now = (bus.rx_data != sum_q);
        default: nak_now = 1'b0;
      endcase
    end else if (expire) begin
      nak_now = 1'b1;
    end
    err_d = sat_add(err_q, {1'b0, nak_now} + {1'b0, drop_now});
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      val_q      <= '0;
      ch_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) trig_q[i] <= '0;
      trig_upd_q <= '0;
      trig_en_q  <= 1'b0;
      cmd_busy_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= '0;
    end else begin
      trig_upd_q <= '0;
      trig_en_q  <= (trig_q[0] | trig_q[1] | trig_q[2] | trig_q[3]) != 8'h00;
      err_q      <= err_d;
      // Every NAK source funnels through nak_now so err_cnt and the response agree
      if (in_frame && nak_now) begin
        state_q    <= RESP;
        tx_valid_q <= 1'b1;
        tx_data_q  <= NAK_BYTE;
      end else begin
        case (state_q)
          IDLE: if (bus.rx_valid && bus.rx_data == SOF_BYTE) begin
            state_q    <= GET_CH;
            sum_q      <= SOF_BYTE;
            cmd_busy_q <= 1'b1;
          end
          GET_CH: if (bus.rx_valid) begin
            ch_q    <= 2'(bus.rx_data - CH_BASE);
            sum_q   <= sum_q ^ bus.rx_data;
            state_q <= GET_VAL;
          end
          GET_VAL: if (bus.rx_valid) begin
            val_q   <= bus.rx_data;
            sum_q   <= sum_q ^ bus.rx_data;
            state_q <= GET_SUM;
          end
          GET_SUM: if (bus.rx_valid) begin
            trig_q[ch_q]     <= val_q;
            trig_upd_q[ch_q] <= 1'b1;
            state_q          <= RESP;
            tx_valid_q       <= 1'b1;
            tx_data_q        <= ACK_BYTE;
          end
          RESP: if (tx_valid_q && bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
            cmd_busy_q <= 1'b0;
          end
          default: begin
            state_q    <= IDLE;
            cmd_busy_q <= 1'b0;
            tx_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign trig_ch0     = trig_q[0];
  assign trig_ch1     = trig_q[1];
  assign trig_ch2     = trig_q[2];
  assign trig_ch3     = trig_q[3];
  assign trig_upd     = trig_upd_q;
  assign trig_en      = trig_en_q;
  assign cmd_busy     = cmd_busy_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_uart_trig_cmd_ctrl.sv
// tb/tb_uart_trig_cmd_ctrl.sv - directed frames with a response scoreboard for uart_trig_cmd_ctrl
module tb_uart_trig_cmd_ctrl;

  localparam int GAP = 20;

  logic       clk;
  logic       nrst;
  logic [7:0] trig_ch0, trig_ch1, trig_ch2, trig_ch3;
  logic [3:0] trig_upd;
  logic       trig_en;
  logic       cmd_busy;
  logic [7:0] err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  uart_trig_cmd_ctrl_if bus ();

  uart_trig_cmd_ctrl #(.GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .bus      (bus),
    .trig_ch0 (trig_ch0),
    .trig_ch1 (trig_ch1),
    .trig_ch2 (trig_ch2),
    .trig_ch3 (trig_ch3),
    .trig_upd (trig_upd),
    .trig_en  (trig_en),
    .cmd_busy (cmd_busy),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: each completed handshake must match the oldest expected byte
  always @(negedge clk) begin
    if (nrst && bus.tx_valid && bus.tx_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got %0h expected none at %0t", bus.tx_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          miscompares++;
          $display("FAIL resp_byte: got %0h expected %0h at %0t", bus.tx_data, e, $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    nrst         = 1'b0;
    bus.rx_valid = 1'b0;
    idle(2);
    nrst = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst         = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    idle(2);
    chk("rst_trig_ch0", trig_ch0, 0);
    chk("rst_trig_en", trig_en, 0);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_err", err_cnt, 0);
    nrst = 1'b1;
    idle(1);

    // Valid write to channel 2
    exp_q.push_back(8'h06);
    send_byte(8'h53); send_byte(8'h32); send_byte(8'hA5); send_byte(8'hC4);
    chk("t1_ch2", trig_ch2, 8'hA5);
    chk("t1_upd", trig_upd, 4'b0100);
    chk("t1_tx_valid", bus.tx_valid, 1);
    chk("t1_en_lag", trig_en, 0);
    idle(1);
    chk("t1_upd_clear", trig_upd, 0);
    chk("t1_en", trig_en, 1);
    chk("t1_busy", cmd_busy, 0);
    chk("t1_err", err_cnt, 0);
    drain();

    // Bad checksum
    do_reset();
    exp_q.push_back(8'h15);
    send_byte(8'h53); send_byte(8'h30); send_byte(8'h7F); send_byte(8'h00);
    chk("t2_upd", trig_upd, 0);
    chk("t2_ch0", trig_ch0, 0);
    chk("t2_err", err_cnt, 1);
    drain();

    // Bad channel, then a good frame
    do_reset();
    exp_q.push_back(8'h15);
    send_byte(8'h53); send_byte(8'h39);
    chk("t3_tx_valid", bus.tx_valid, 1);
    chk("t3_err", err_cnt, 1);
    idle(1);
    chk("t3_idle", cmd_busy, 0);
    exp_q.push_back(8'h06);
    send_byte(8'h53); send_byte(8'h31); send_byte(8'h01); send_byte(8'h63);
    chk("t3_ch1", trig_ch1, 8'h01);
    chk("t3_upd", trig_upd, 4'b0010);
    drain();
    chk("t3_err_final", err_cnt, 1);

    // Gap timeout
    do_reset();
    exp_q.push_back(8'h15);
    send_byte(8'h53); send_byte(8'h33);
    idle(GAP - 1);
    chk("t4_before_timeout", bus.tx_valid, 0);
    idle(1);
    chk("t4_at_timeout", bus.tx_valid, 1);
    chk("t4_err", err_cnt, 1);
    drain();

    // Byte coinciding with the timeout cycle restarts the timer
    do_reset();
    send_byte(8'h53); send_byte(8'h33);
    idle(GAP - 1);
    send_byte(8'h44);
    chk("t4b_no_nak", bus.tx_valid, 0);
    chk("t4b_busy", cmd_busy, 1);
    idle(GAP - 2);
    chk("t4b_still_waiting", bus.tx_valid, 0);
    exp_q.push_back(8'h06);
    send_byte(8'h24);
    chk("t4b_ch3", trig_ch3, 8'h44);
    chk("t4b_err", err_cnt, 0);
    drain();

    // Stalled response while bytes arrive
    do_reset();
    bus.tx_ready = 1'b0;
    exp_q.push_back(8'h06);
    send_byte(8'h53); send_byte(8'h30); send_byte(8'h5A); send_byte(8'h39);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send_byte(8'h53);
      else if (i == 30) send_byte(8'h31);
      else idle(1);
      chk("t5_hold_valid", bus.tx_valid, 1);
      chk("t5_hold_data", bus.tx_data, 8'h06);
    end
    chk("t5_err", err_cnt, 2);
    bus.tx_ready = 1'b1;
    idle(1);
    chk("t5_released", bus.tx_valid, 0);
    chk("t5_not_parsed", cmd_busy, 0);
    chk("t5_ch0", trig_ch0, 8'h5A);
    idle(3);
    chk("t5_no_extra", bus.tx_valid, 0);
    drain();

    // Reset mid-frame
    do_reset();
    exp_q.push_back(8'h06);
    send_byte(8'h53); send_byte(8'h32); send_byte(8'h11); send_byte(8'h70);
    idle(1);
    chk("t6_pre_en", trig_en, 1);
    drain();
    send_byte(8'h53); send_byte(8'h30); send_byte(8'hAA);
    nrst = 1'b0;
    #1;
    chk("t6_ch2", trig_ch2, 0);
    chk("t6_en", trig_en, 0);
    chk("t6_busy", cmd_busy, 0);
    chk("t6_tx_valid", bus.tx_valid, 0);
    chk("t6_upd", trig_upd, 0);
    idle(2);
    nrst = 1'b1;
    idle(1);
    send_byte(8'h63);
    idle(5);
    chk("t6_ignored_busy", cmd_busy, 0);
    chk("t6_ignored_tx", bus.tx_valid, 0);
    chk("t6_ignored_err", err_cnt, 0);
    chk("t6_ch0", trig_ch0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
